// File: rtl/neo_c43_bd3_fd2_pkg.sv
// neo_c43_bd3_fd2_pkg: shared counter width and terminal-count constant
package neo_c43_bd3_fd2_pkg;
  localparam int CNT_W_DEF = 4;
  localparam logic [CNT_W_DEF-1:0] CNT_ONES = '1;
endpackage

// File: rtl/neo_c43_bd3_fd2_if.sv
// neo_c43_bd3_fd2_if: data bundle for the counter, buffer and flop cells
interface neo_c43_bd3_fd2_if #(parameter int CNT_W = 4);
  logic [CNT_W-1:0] C_D;
  logic C_NLOAD;
  logic C_EN;
  logic C_CI;
  logic [CNT_W-1:0] C_Q;
  logic C_CO;
  logic B_IN;
  logic B_OUT;
  logic F_D;
  logic F_Q;
  logic F_NQ;
  modport master (output C_D, C_NLOAD, C_EN, C_CI, B_IN, F_D, input C_Q, C_CO, B_OUT, F_Q, F_NQ);
  modport slave (input C_D, C_NLOAD, C_EN, C_CI, B_IN, F_D, output C_Q, C_CO, B_OUT, F_Q, F_NQ);
endinterface

// File: rtl/neo_c43_counter.sv
// neo_c43_counter: C43 loadable up-counter with ENP/ENT enables and carry-out
module neo_c43_counter #(
  parameter int W = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic [W-1:0] d,
  input  logic nload,
  input  logic en,
  input  logic ci,
  output logic [W-1:0] q,
  output logic co
);
  // load beats count; counting needs both ENP and ENT
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RST_VAL;
    else q <= !nload ? d : (en && ci) ? q + 1'b1 : q;
  // carry depends only on ENT and the terminal count, so cells chain cleanly
  assign co = ci && (q == {W{1'b1}});
endmodule

// File: rtl/neo_c43_bd3_fd2.sv
// neo_c43_bd3_fd2: C43 counter, BD3 buffer and FD2 flop on one clock
module neo_c43_bd3_fd2
  import neo_c43_bd3_fd2_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] CNT_RST = '0
) (
  input logic CLK,
  input logic RESET,
  neo_c43_bd3_fd2_if.slave bus
);
  logic f_q;
  neo_c43_counter #(.W(CNT_W), .RST_VAL(CNT_RST)) u_cnt (
    .clk(CLK),
    .rst(RESET),
    .d(bus.C_D),
    .nload(bus.C_NLOAD),
    .en(bus.C_EN),
    .ci(bus.C_CI),
    .q(bus.C_Q),
    .co(bus.C_CO)
  );
  assign bus.B_OUT = bus.B_IN;
  // FD2 flop; the complement is derived so it tracks through reset
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) f_q <= 1'b0;
    else f_q <= bus.F_D;
  assign bus.F_Q = f_q;
  assign bus.F_NQ = ~f_q;
endmodule

// File: tb/tb_neo_c43_bd3_fd2.sv
// tb_neo_c43_bd3_fd2: scoreboard bench for the C43/BD3/FD2 cell bundle
module tb_neo_c43_bd3_fd2;
  typedef struct packed {
    logic [3:0] q;
    logic co;
    logic fq;
    logic fnq;
  } exp_t;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic loop = 1'b0;
  logic nload = 1'b1;
  logic [3:0] m_q = 4'd0;
  logic m_f = 1'b0;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  neo_c43_bd3_fd2_if #(.CNT_W(4)) bus ();
  neo_c43_bd3_fd2 #(.CNT_W(4), .CNT_RST(4'd0)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  assign bus.C_NLOAD = loop ? ~bus.C_CO : nload;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    logic nl;
    nl = loop ? ~(bus.C_CI && m_q == 4'hF) : nload;
    m_q = !nl ? bus.C_D : (bus.C_EN && bus.C_CI) ? m_q + 4'd1 : m_q;
    m_f = bus.F_D;
    e.q = m_q;
    e.co = bus.C_CI && (m_q == 4'hF);
    e.fq = m_f;
    e.fnq = ~m_f;
    sb.push_back(e);
    #1 CLK = 1'b1;
    #1;
    e = sb.pop_front();
    check("c_q", 32'(bus.C_Q), 32'(e.q));
    check("c_co", 32'(bus.C_CO), 32'(e.co));
    check("f_q", 32'(bus.F_Q), 32'(e.fq));
    check("f_nq", 32'(bus.F_NQ), 32'(e.fnq));
    #4 CLK = 1'b0;
    #4;
  endtask
  task automatic pulse_reset();
    #2 RESET = 1'b1;
    m_q = 4'd0;
    m_f = 1'b0;
    #1;
    check("rst_c_q", 32'(bus.C_Q), 32'd0);
    check("rst_c_co", 32'(bus.C_CO), 32'd0);
    check("rst_f_q", 32'(bus.F_Q), 32'd0);
    check("rst_f_nq", 32'(bus.F_NQ), 32'd1);
    #2 RESET = 1'b0;
    #2;
  endtask
  initial begin
    bus.C_D = 4'd0;
    bus.C_EN = 1'b1;
    bus.C_CI = 1'b1;
    bus.B_IN = 1'b0;
    bus.F_D = 1'b1;
    pulse_reset();
    tick();
    pulse_reset();
    for (int i = 0; i < 16; i++) tick();
    bus.C_D = 4'hF;
    nload = 1'b0;
    tick();
    nload = 1'b1;
    bus.C_EN = 1'b0;
    tick();
    bus.C_CI = 1'b0;
    #1 check("co_ci0", 32'(bus.C_CO), 32'd0);
    tick();
    bus.C_D = 4'd5;
    nload = 1'b0;
    tick();
    bus.C_D = 4'hE;
    bus.C_EN = 1'b1;
    bus.C_CI = 1'b1;
    tick();
    nload = 1'b1;
    tick();
    tick();
    bus.C_D = 4'hA;
    nload = 1'b0;
    tick();
    nload = 1'b1;
    loop = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    loop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.B_IN = i[0];
      #1 check("b_out", 32'(bus.B_OUT), 32'(i[0]));
    end
    bus.F_D = 1'b1;
    tick();
    bus.F_D = 1'b0;
    tick();
    bus.F_D = 1'b1;
    tick();
    pulse_reset();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
